// File: rtl/mpc_chan_sram_responder.sv
// mpc_chan_sram_responder: SRAM-backed responder for the mpc channel request/response protocol.
// Accepts LOAD/STORE beats on a valid/ready request port and returns load data, in order, on a
// valid/ready response port through a fixed-latency read pipeline and a credit-guarded FIFO.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_op, req_addr, req_wdata     request beat (byte address, store data)
//   rsp_valid/rsp_ready, rsp_rdata  load response handshake and data
//   illegal_cnt                     saturating count of accepted illegal-op beats
//   busy                            a load is in the pipeline or the response FIFO
module mpc_chan_sram_responder #(
   parameter int OP_WIDTH       = 3,
   parameter int DATA_WIDTH     = 128,
   parameter int ADDR_WIDTH     = 32,
   parameter int DEPTH_LOG2     = 6,
   parameter int LATENCY        = 2,
   parameter int RSP_FIFO_DEPTH = 4,
   parameter logic [OP_WIDTH-1:0] OP_LOAD  = 3'd1,
   parameter logic [OP_WIDTH-1:0] OP_STORE = 3'd2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_WIDTH-1:0]   req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [7:0]            illegal_cnt,
   output logic                  busy
);
   localparam int OFF = $clog2(DATA_WIDTH / 8);
   localparam int PW  = $clog2(RSP_FIFO_DEPTH);
   localparam int CW  = PW + 1;

   logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
   logic [LATENCY-1:0]    pv;
   logic [DATA_WIDTH-1:0] pd [LATENCY];
   logic [DATA_WIDTH-1:0] fifo [RSP_FIFO_DEPTH];
   logic [PW-1:0]         wp, rp;
   logic [CW-1:0]         cnt, inflight;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  acc, is_ld, is_st, is_ill, push, pop;

   // Credit is taken from registered state only, so a pop this cycle frees nothing until next cycle.
   always_comb begin
      inflight = cnt;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(pv[i]);
   end

   assign idx       = req_addr[OFF +: DEPTH_LOG2];
   assign req_ready = rst_n && (inflight < CW'(RSP_FIFO_DEPTH));
   assign acc       = req_valid && req_ready;
   assign is_ld     = acc && (req_op == OP_LOAD);
   assign is_st     = acc && (req_op == OP_STORE);
   assign is_ill    = acc && !is_ld && !is_st;
   assign push      = pv[LATENCY-1];
   assign rsp_valid = (cnt != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_rdata = fifo[rp];
   assign busy      = (inflight != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
      end else if (is_st) begin
         mem[idx] <= req_wdata;
      end
   end

   // Stage 0 captures the SRAM read at the accept edge; the FIFO push happens LATENCY edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
      end else begin
         pv[0] <= is_ld;
         pd[0] <= mem[idx];
         for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         for (int i = 0; i < RSP_FIFO_DEPTH; i++) fifo[i] <= '0;
      end else begin
         if (push) begin
            fifo[wp] <= pd[LATENCY-1];
            wp       <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_cnt <= '0;
      else if (is_ill && illegal_cnt != 8'hff) illegal_cnt <= illegal_cnt + 8'd1;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (pop || cnt < CW'(RSP_FIFO_DEPTH)));
endmodule

// File: tb/tb_mpc_chan_sram_responder.sv
// tb_mpc_chan_sram_responder: directed self-checking bench for mpc_chan_sram_responder.
module tb_mpc_chan_sram_responder;
   localparam logic [2:0] LD = 3'd1;
   localparam logic [2:0] ST = 3'd2;

   logic         clk = 0;
   logic         rst_n = 0;
   logic         req_valid = 0;
   logic         req_ready;
   logic [2:0]   req_op = '0;
   logic [31:0]  req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic         rsp_valid;
   logic         rsp_ready = 0;
   logic [127:0] rsp_rdata;
   logic [7:0]   illegal_cnt;
   logic         busy;

   int total = 0;
   int bad = 0;
   int acc_n;

   mpc_chan_sram_responder dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .illegal_cnt(illegal_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [127:0] d);
      int n;
      @(negedge clk);
      req_valid = 1;
      req_op    = op;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept", req_ready, 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic get_rsp(input string tag, input logic [127:0] e);
      int n;
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_v"}, rsp_valid, 1);
      check(tag, rsp_rdata, e);
      rsp_ready = 1;
      @(posedge clk);
      #1 rsp_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_ill", illegal_cnt, 0);
      check("rst_busy", busy, 0);
      rst_n = 1;
      issue(LD, 32'h40, 0);
      idle();
      get_rsp("ld40", 0);

      // store then load next cycle, latency 2
      issue(ST, 32'hA0, 128'haaaa_bbbb_cccc_dddd);
      issue(LD, 32'hA0, 0);
      idle();
      check("lat_e0", rsp_valid, 0);
      check("busy_ld", busy, 1);
      @(negedge clk);
      check("lat_e1", rsp_valid, 0);
      @(negedge clk);
      check("lat_e2", rsp_valid, 1);
      check("lat_data", rsp_rdata, 128'haaaa_bbbb_cccc_dddd);
      get_rsp("ldA0", 128'haaaa_bbbb_cccc_dddd);

      // stall: rsp_ready low, six back-to-back loads, only four accepted
      for (int i = 1; i <= 6; i++) issue(ST, 32'(i << 4), 128'h1000 + 128'(i));
      acc_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 1;
         req_op    = LD;
         req_addr  = 32'((acc_n + 1) << 4);
         if (req_ready) acc_n++;
         @(posedge clk);
      end
      idle();
      check("stall_acc", acc_n, 4);
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
      for (int i = 1; i <= 4; i++) get_rsp("stall_rsp", 128'h1000 + 128'(i));
      issue(LD, 32'h50, 0);
      issue(LD, 32'h60, 0);
      idle();
      get_rsp("stall_r5", 128'h1005);
      get_rsp("stall_r6", 128'h1006);

      // alias and top word
      issue(ST, 32'h400, 1);
      issue(LD, 32'h0, 0);
      idle();
      get_rsp("alias0", 1);
      issue(ST, 32'h3F0, 128'h63);
      issue(LD, 32'h3F0, 0);
      issue(LD, 32'h7F0, 0);
      issue(LD, 32'h0, 0);
      idle();
      get_rsp("w63", 128'h63);
      get_rsp("w63_alias", 128'h63);
      get_rsp("w0_keep", 1);

      // FIFO pointer wrap: four bursts of three loads
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 3; j++) issue(LD, 32'((((r * 3 + j) % 6) + 1) << 4), 0);
         idle();
         for (int j = 0; j < 3; j++) get_rsp("wrap", 128'h1000 + 128'(((r * 3 + j) % 6) + 1));
      end

      // illegal ops saturate the counter and touch nothing
      for (int i = 0; i < 300; i++) issue(3'b111, 32'h10, '1);
      idle();
      repeat (3) @(negedge clk);
      check("ill_cnt", illegal_cnt, 255);
      check("ill_rsp", rsp_valid, 0);
      check("ill_busy", busy, 0);
      issue(LD, 32'h10, 0);
      idle();
      get_rsp("ill_mem", 128'h1001);

      // reset with loads in flight
      issue(LD, 32'h10, 0);
      issue(LD, 32'h20, 0);
      issue(LD, 32'h30, 0);
      idle();
      check("mid_valid", rsp_valid, 1);
      #2 rst_n = 0;
      #1;
      check("arst_valid", rsp_valid, 0);
      check("arst_ready", req_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_ill", illegal_cnt, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (5) @(negedge clk);
      check("post_valid", rsp_valid, 0);
      check("post_busy", busy, 0);
      issue(LD, 32'h10, 0);
      idle();
      get_rsp("post_clr", 0);
      check("post_busy2", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
